counter_param: RTL and testbench
================================

// Module: counter_param
// PURPOSE
//   Parametrised synchronous up/down counter, the successor to the fixed 32-bit
//   ripple-enable counter. Adds run-time modulus (limit), parallel load, sync
//   clear, direction control, and wrap or saturate mode.
//   Also provides terminal-count, compare-match and sticky-overflow flags.
//   Used for processor cycle/event counting and timer/timeout generation.
// PARAMETERS
//   WIDTH      32  counter width in bits (>=2)
//   SATURATE   0   0 = wrap at bounds, 1 = hold at bounds
//   RESET_VAL  0   value of count after reset (WIDTH bits)
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   en        in   1      count enable; counter advances one step per enabled cycle
//   up_down   in   1      1 = count up, 0 = count down
//   clear     in   1      synchronous clear of count to 0
//   load      in   1      synchronous load of load_val
//   load_val  in   WIDTH  value loaded when load=1
//   limit     in   WIDTH  upper bound; count range is 0..limit
//   compare   in   WIDTH  compare value for match
//   ovf_clr   in   1      clears the overflow flag
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal-count pulse (registered, 1 cycle)
//   match     out  1      count == compare (combinational from count register)
//   overflow  out  1      sticky bound-event flag (registered)
// BEHAVIOUR
//   Reset (async):
//   - count=RESET_VAL, tc=0, overflow=0; match follows count.
//   Per-edge priority: clear > load > en; idle otherwise (count holds, tc=0).
//   clear:
//   - count<=0, tc<=0.
//   load:
//   - count<=load_val, tc<=0.
//   - load_val is loaded unmodified even if > limit.
//   en, up_down=1:
//   - If count>=limit, this is a bound event: count<=0 (wrap) or count<=limit (SATURATE).
//   - Otherwise count<=count+1.
//   en, up_down=0:
//   - If count==0, this is a bound event: count<=limit (wrap) or count<=0 (SATURATE).
//   - Otherwise count<=count-1.
//   - A value above limit decrements normally.
//   Bound event:
//   - tc<=1 for exactly the following cycle.
//   - overflow<=1, also in SATURATE mode on every held-at-bound enabled cycle.
//   - Consecutive bound events give tc high on consecutive cycles.
//   overflow:
//   - Set by a bound event; cleared by ovf_clr.
//   - A bound event in the same cycle as ovf_clr leaves it set.
//   - Not affected by clear or load.
//   limit=0:
//   - count stays 0.
//   - Every enabled cycle is a bound event (tc held high while en=1).
//   Arithmetic:
//   - Unsigned, modulo 2^WIDTH internally.
//   - No count value outside 0..max(limit, loaded value) is ever produced.
//   limit/compare:
//   - May change any cycle; the new value is used on the next edge.
//   - No hold-registers.
//   Latency:
//   - count, tc and overflow update 1 cycle after the qualifying edge.
//   - match is 0-cycle from count.
//   Reset asserted mid-count overrides all inputs immediately (asynchronously).
// TESTING
//   1. WIDTH=8, limit=5, up, en=1 from 0:
//      count 0,1,2,3,4,5,0,1.
//      tc=1 only the cycle count reads 0 after 5; overflow=1 thereafter.
//   2. Down, limit=9, count=0, one enabled cycle, SATURATE=0:
//      count=9, tc pulse.
//      Same with SATURATE=1: count stays 0, tc=1, overflow=1.
//   3. load_val=0xF0, limit=0x10, load=1 then en up:
//      count 0xF0 -> 0x00 with a tc pulse.
//      clear+load+en together: count=0.
//   4. compare=3, count up from 0:
//      match=1 exactly while count==3.
//      ovf_clr with a simultaneous bound event: overflow stays 1.
//      ovf_clr alone: overflow=0.
//   5. WIDTH=32, load 0xFFFFFFFE, limit=0xFFFFFFFF, up:
//      count ...FFFF, then 0 with tc.
//      Async reset mid-count with RESET_VAL=7: count=7, tc=0 without waiting for clk.

Source files
------------

// File: rtl/counter_param.sv
// Parametrised up/down counter with run-time modulus, load, clear, wrap/saturate
// mode, terminal-count pulse, compare match and sticky overflow flag.
module counter_param #(
    parameter int               WIDTH     = 32,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] compare,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             match,
    output logic             overflow
);

    localparam bit SAT = (SATURATE != 0);

    logic [WIDTH-1:0] count_nxt;
    logic             bound_up;
    logic             bound_dn;
    logic             bound;
    logic             ovf_nxt;

    // ">=" rather than "==" so a loaded value above limit still hits the bound
    assign bound_up = (count >= limit);
    assign bound_dn = (count == '0);

    always_comb begin
        count_nxt = count;
        bound     = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = load_val;
        end else if (en) begin
            if (up_down) begin
                if (bound_up) begin
                    bound     = 1'b1;
                    count_nxt = SAT ? limit : '0;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (bound_dn) begin
                    bound     = 1'b1;
                    count_nxt = SAT ? '0 : limit;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    // a bound event on the same edge as ovf_clr wins
    assign ovf_nxt = bound | (overflow & ~ovf_clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= RESET_VAL;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            count    <= count_nxt;
            tc       <= bound;
            overflow <= ovf_nxt;
        end
    end

    assign match = (count == compare);

endmodule

// File: tb/tb_counter_param.sv
// Bench: three counters (8-bit wrap, 8-bit saturate, 32-bit wrap with RESET_VAL=7)
// on shared controls, checked every cycle against a behavioural model plus directed literals.
module tb_counter_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, up_down = 1'b0, clear = 1'b0, load = 1'b0, ovf_clr = 1'b0;
    logic [7:0]  load_val8 = '0, limit8 = '0, compare8 = '0;
    logic [31:0] load_val32 = '0, limit32 = '0, compare32 = '0;

    logic [7:0]  cnt_a, cnt_b;
    logic [31:0] cnt_c;
    logic tc_a, tc_b, tc_c, m_a, m_b, m_c, ov_a, ov_b, ov_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_param #(.WIDTH(8), .SATURATE(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
        .load_val(load_val8), .limit(limit8), .compare(compare8), .ovf_clr(ovf_clr),
        .count(cnt_a), .tc(tc_a), .match(m_a), .overflow(ov_a));

    counter_param #(.WIDTH(8), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
        .load_val(load_val8), .limit(limit8), .compare(compare8), .ovf_clr(ovf_clr),
        .count(cnt_b), .tc(tc_b), .match(m_b), .overflow(ov_b));

    counter_param #(.WIDTH(32), .SATURATE(0), .RESET_VAL(32'd7)) dut_c (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .clear(clear), .load(load),
        .load_val(load_val32), .limit(limit32), .compare(compare32), .ovf_clr(ovf_clr),
        .count(cnt_c), .tc(tc_c), .match(m_c), .overflow(ov_c));

    // ---------------- behavioural model ----------------
    localparam int          MW  [3] = '{8, 8, 32};
    localparam bit          MS  [3] = '{1'b0, 1'b1, 1'b0};
    localparam longint      MRV [3] = '{0, 0, 7};

    longint m_cnt [3];
    bit     m_tc  [3];
    bit     m_ovf [3];

    function automatic longint in_lim(int k);
        return (k == 2) ? longint'(limit32) : longint'(limit8);
    endfunction
    function automatic longint in_lv(int k);
        return (k == 2) ? longint'(load_val32) : longint'(load_val8);
    endfunction
    function automatic longint in_cmp(int k);
        return (k == 2) ? longint'(compare32) : longint'(compare8);
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            longint c, lim, nc;
            bit     ev;
            c   = m_cnt[k];
            lim = in_lim(k);
            nc  = c;
            ev  = 1'b0;
            if (reset) begin
                m_cnt[k] <= MRV[k];
                m_tc[k]  <= 1'b0;
                m_ovf[k] <= 1'b0;
            end else begin
                if (clear)     nc = 0;
                else if (load) nc = in_lv(k);
                else if (en) begin
                    if (up_down) begin
                        if (c >= lim) begin ev = 1; nc = MS[k] ? lim : 0; end
                        else nc = c + 1;
                    end else begin
                        if (c == 0) begin ev = 1; nc = MS[k] ? 0 : lim; end
                        else nc = c - 1;
                    end
                end
                m_cnt[k] <= nc;
                m_tc[k]  <= ev;
                m_ovf[k] <= ev ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[k]);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] d_cnt(int k);
        case (k)
            0:       return 64'(cnt_a);
            1:       return 64'(cnt_b);
            default: return 64'(cnt_c);
        endcase
    endfunction
    function automatic logic [3:0] d_flags(int k); // {tc, match, overflow, 0}
        case (k)
            0:       return {tc_a, m_a, ov_a, 1'b0};
            1:       return {tc_b, m_b, ov_b, 1'b0};
            default: return {tc_c, m_c, ov_c, 1'b0};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] f;
                f = d_flags(k);
                chk($sformatf("model count[%0d]", k), d_cnt(k), 64'(m_cnt[k]));
                chk($sformatf("model tc[%0d]", k), 64'(f[3]), 64'(m_tc[k]));
                chk($sformatf("model match[%0d]", k), 64'(f[2]), 64'(m_cnt[k] == in_cmp(k)));
                chk($sformatf("model overflow[%0d]", k), 64'(f[1]), 64'(m_ovf[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick();
        chk("reset cnt_a", 64'(cnt_a), 64'd0);
        chk("reset cnt_c", 64'(cnt_c), 64'd7);
        chk("reset tc_a", 64'(tc_a), 64'd0);
        chk("reset ov_a", 64'(ov_a), 64'd0);
        chk("reset match_a", 64'(m_a), 64'd1);
        reset = 1'b0;

        // wrap at limit=5
        limit8 = 8'd5; up_down = 1'b1; en = 1'b1; compare8 = 8'd200;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("t1 cnt step%0d", i), 64'(cnt_a), 64'(i % 6));
            chk($sformatf("t1 tc step%0d", i), 64'(tc_a), 64'(i == 6));
            chk($sformatf("t1 ovf step%0d", i), 64'(ov_a), 64'(i >= 6));
        end

        // down from 0, limit=9
        en = 1'b0; clear = 1'b1; tick();
        clear = 1'b0; limit8 = 8'd9; up_down = 1'b0; en = 1'b1; tick();
        en = 1'b0;
        chk("t2 wrap cnt", 64'(cnt_a), 64'd9);
        chk("t2 wrap tc", 64'(tc_a), 64'd1);
        chk("t2 sat cnt", 64'(cnt_b), 64'd0);
        chk("t2 sat tc", 64'(tc_b), 64'd1);
        chk("t2 sat ovf", 64'(ov_b), 64'd1);
        tick();
        chk("t2 tc one cycle", 64'(tc_a), 64'd0);

        // load above limit then count up
        load_val8 = 8'hF0; limit8 = 8'h10; load = 1'b1; tick();
        load = 1'b0;
        chk("t3 load cnt", 64'(cnt_a), 64'hF0);
        up_down = 1'b1; en = 1'b1; tick();
        chk("t3 wrap cnt", 64'(cnt_a), 64'h00);
        chk("t3 wrap tc", 64'(tc_a), 64'd1);
        chk("t3 sat cnt", 64'(cnt_b), 64'h10);
        clear = 1'b1; load = 1'b1; tick();
        chk("t3 clr>load cnt", 64'(cnt_a), 64'd0);
        chk("t3 clr>load tc", 64'(tc_a), 64'd0);
        clear = 1'b0; load = 1'b0;

        // compare match and overflow clearing
        limit8 = 8'd9; compare8 = 8'd3;
        chk("t4 match at 0", 64'(m_a), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("t4 cnt %0d", i), 64'(cnt_a), 64'(i));
            chk($sformatf("t4 match %0d", i), 64'(m_a), 64'(i == 3));
        end
        en = 1'b0; ovf_clr = 1'b1; tick();
        chk("t4 ovf_clr alone", 64'(ov_a), 64'd0);
        limit8 = 8'd0; en = 1'b1; tick();
        chk("t4 bound beats clr", 64'(ov_a), 64'd1);
        chk("t4 lim0 cnt", 64'(cnt_a), 64'd0);
        ovf_clr = 1'b0; tick();
        chk("t4 lim0 stays 0", 64'(cnt_a), 64'd0);
        chk("t4 lim0 tc held", 64'(tc_a), 64'd1);
        en = 1'b0; ovf_clr = 1'b1; tick();
        chk("t4 ovf cleared", 64'(ov_a), 64'd0);
        ovf_clr = 1'b0;

        // 32-bit top-end wrap, then async reset
        load_val32 = 32'hFFFF_FFFE; limit32 = 32'hFFFF_FFFF; load = 1'b1; tick();
        load = 1'b0; up_down = 1'b1; en = 1'b1;
        chk("t5 load", 64'(cnt_c), 64'hFFFF_FFFE);
        tick();
        chk("t5 max", 64'(cnt_c), 64'hFFFF_FFFF);
        chk("t5 no tc", 64'(tc_c), 64'd0);
        tick();
        chk("t5 wrap", 64'(cnt_c), 64'd0);
        chk("t5 wrap tc", 64'(tc_c), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5 async cnt", 64'(cnt_c), 64'd7);
        chk("t5 async tc", 64'(tc_c), 64'd0);
        tick();
        reset = 1'b0;

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            clear   = ($urandom_range(0, 15) == 0);
            load    = ($urandom_range(0, 15) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_down = ($urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0)
                limit8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 20));
            load_val8 = 8'($urandom);
            compare8  = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0)
                case ($urandom_range(0, 2))
                    0:       limit32 = 32'($urandom_range(0, 20));
                    1:       limit32 = 32'hFFFF_FFFF;
                    default: limit32 = 32'hFFFF_FFF0;
                endcase
            load_val32 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 30))
                                                     : (32'hFFFF_FFE8 + 32'($urandom_range(0, 23)));
            compare32  = 32'($urandom_range(0, 10));
            reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
